// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and stream framing constants for the imem loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic int unsigned stream_bytes(input int unsigned n_words);
        return HDR_BYTES + BYTES_PER_WORD * n_words + 1;
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: little-endian byte-to-word assembler with running XOR checksum
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [7:0]  csum_o
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] buf_q, buf_d;
    logic [7:0]  csum_q, csum_d;

    // The word completes with the incoming byte, so the top lane is taken straight from the input
    assign word_o       = {byte_i, buf_q};
    assign word_valid_o = byte_valid_i && (lane_q == LAST_LANE);
    assign csum_o       = csum_q;

    // Shift bytes down from the top so the first byte ends in the least significant lane
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        csum_d = csum_q;
        if (clr_i) begin
            lane_d = '0;
            buf_d  = '0;
            csum_d = '0;
        end else if (byte_valid_i) begin
            lane_d = lane_q + 2'd1;
            buf_d  = {byte_i, buf_q[23:8]};
            csum_d = csum_q ^ byte_i;
        end
    end

    // Lane counter, partial word and checksum registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
            buf_q  <= '0;
            csum_q <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
            csum_q <= csum_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills imem and holds the core until the image verifies
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              acc;
    logic              byte_v;
    logic              clr;
    logic              word_v;
    logic [31:0]       word;
    logic [7:0]        csum;
    logic [CNT_W-1:0]  n_hdr;

    assign acc    = in_valid && rdy_q;
    assign byte_v = acc && (state_q == S_DATA);
    assign clr    = reload && (state_q == S_DONE || state_q == S_ERR);
    assign n_hdr  = CNT_W'({in_data, cnt_q[7:0]});

    loader_word_asm u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .byte_valid_i (byte_v),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_v),
        .csum_o       (csum)
    );

    // Header decode, word write sequencing, checksum verdict and reload handling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_HDR0: if (acc) begin
                cnt_d   = CNT_W'(in_data);
                state_d = S_HDR1;
            end
            S_HDR1: if (acc) begin
                cnt_d   = n_hdr;
                state_d = (32'(n_hdr) > 32'(DEPTH)) ? S_ERR : (n_hdr == '0) ? S_CHK : S_DATA;
            end
            S_DATA: if (word_v) begin
                we_d    = 1'b1;
                addr_d  = widx_q[ADDR_W-1:0];
                wdata_d = word;
                widx_d  = widx_q + CNT_W'(1);
                state_d = (widx_q == cnt_q - CNT_W'(1)) ? S_CHK : S_DATA;
            end
            S_CHK: if (acc) state_d = (in_data == csum) ? S_DONE : S_ERR;
            default: if (clr) begin
                state_d = S_HDR0;
                cnt_d   = '0;
                widx_d  = '0;
            end
        endcase
        rdy_d = state_d inside {S_HDR0, S_HDR1, S_DATA, S_CHK};
    end

    // State, counters and registered imem write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR0;
            cnt_q   <= '0;
            widx_q  <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign cpu_hold   = (state_q != S_DONE);

endmodule
